// File: rtl/eth_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : eth_pkg                                                  |
// | Description : Shared types and constants for the Ethernet FIFO read    |
// |               path: ingress state encoding and FIFO word layout.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package eth_pkg;

    // Ingress state of the stream reader (tracks words leaving the FIFO).
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FRAME = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_t;

    // Default payload width; a FIFO word is {last, data}, so the last flag
    // sits at bit index DATA_W.
    localparam int ETH_DATA_W = 8;
    localparam int LAST_BIT   = ETH_DATA_W;

endpackage
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : stream_buf2                                              |
// | Description : Two-entry FIFO holding words that have left the external |
// |               FIFO but not yet been handed to the stream sink.         |
// | Ports       : clk, rst_n (sync, active-low), i_push/i_din write side,  |
// |               i_pop read side, i_clear drops all entries, o_occ entry  |
// |               count (0..2), o_head oldest entry.                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module stream_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_din,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem0   <= '0;
            r_mem1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_clear) begin
            // Storage is left as-is; only the bookkeeping is emptied.
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                if (r_wr_ptr) begin
                    r_mem1 <= i_din;
                end else begin
                    r_mem0 <= i_din;
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_rd_ptr ? r_mem1 : r_mem0;

endmodule
`default_nettype wire

// File: rtl/afifo_stream_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : afifo_stream_reader                                      |
// | Description : Read-side engine of the dual-clock FIFO. Pops {last,data}|
// |               words, hides the 1-cycle registered read latency behind  |
// |               a 2-entry buffer and drives a zero-bubble valid/ready    |
// |               stream. Tracks frames, flushes the rest of a frame on    |
// |               request and counts delivered / dropped frames.           |
// | Ports       : clk, rst_n (sync, active-low)                            |
// |               fifo_re / fifo_rempty / fifo_rdata - FIFO read port      |
// |               m_valid / m_ready / m_data / m_last - output stream      |
// |               flush     - pulse, drop remainder of current frame       |
// |               frame_cnt - delivered frames (saturating)                |
// |               drop_cnt  - flushed frames (saturating)                  |
// |               busy      - ingress FSM not idle                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module afifo_stream_reader
    import eth_pkg::*;
#(
    parameter int DATA_W = ETH_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fifo_re,
    input  logic              fifo_rempty,
    input  logic [DATA_W:0]   fifo_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              flush,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam int c_last_bit = DATA_W;

    rd_state_t          r_state;
    rd_state_t          w_state_next;
    logic               r_inflight;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic [1:0]         w_occ;
    logic [DATA_W:0]    w_head;
    logic               w_in_last;
    logic               w_flush_hit;
    logic               w_dropping;
    logic               w_push;
    logic               w_pop;
    logic               w_drop_done;
    logic [2:0]         w_credit;

    assign w_in_last   = fifo_rdata[c_last_bit];
    // A flush only acts while a frame is being received; elsewhere it is ignored.
    assign w_flush_hit = flush & (r_state == RD_FRAME);
    // The in-flight word is discarded while flushing, including the cycle the
    // flush arrives.
    assign w_dropping  = w_flush_hit | (r_state == RD_FLUSH);
    assign w_push      = r_inflight & ~w_dropping;
    // A flush clears the buffer, so a coinciding handshake is not honoured.
    assign w_pop       = m_valid & m_ready & ~w_flush_hit;
    assign w_drop_done = r_inflight & w_in_last & w_dropping;

    // Slots already claimed: buffered words plus the word in flight, minus the
    // head leaving this cycle. Counting the departing head as free is what
    // lets the reader sustain one word per cycle with only two entries.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_re  = rst_n & ~fifo_rempty & (w_credit < 3'd2);

    stream_buf2 #(
        .WIDTH (DATA_W + 1)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_flush_hit),
        .i_din   (fifo_rdata),
        .o_occ   (w_occ),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RD_IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= fifo_re;
        end
    end

    // Ingress FSM: advances on words arriving from the FIFO, not on the
    // output handshake.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RD_IDLE: begin
                if (r_inflight && !w_in_last) begin
                    w_state_next = RD_FRAME;
                end
            end
            RD_FRAME: begin
                if (flush) begin
                    // A flush racing the final word finishes the drop at once.
                    w_state_next = (r_inflight && w_in_last) ? RD_IDLE : RD_FLUSH;
                end else if (r_inflight && w_in_last) begin
                    w_state_next = RD_IDLE;
                end
            end
            RD_FLUSH: begin
                if (r_inflight && w_in_last) begin
                    w_state_next = RD_IDLE;
                end
            end
            default: w_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_pop && m_last && (r_frame_cnt != {CNT_W{1'b1}})) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_drop_done && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign m_valid   = (w_occ != 2'd0);
    assign m_data    = w_head[DATA_W-1:0];
    assign m_last    = w_head[c_last_bit];
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = (r_state != RD_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_afifo_stream_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_afifo_stream_reader                                   |
// | Description : Self-checking bench for afifo_stream_reader. A simple    |
// |               FIFO model feeds the reader; a queue of expected words   |
// |               checks every output handshake.                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_afifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_re;
    logic          fifo_rempty;
    logic [DW:0]   fifo_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          flush;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;
    logic          busy;

    always #5 clk = ~clk;

    afifo_stream_reader #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_re     (fifo_re),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .flush       (flush),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    // FIFO model: storage and write pointer belong to the stimulus, read
    // pointer to this block. Registered empty flag, data one cycle after re.
    logic [DW:0] mem [0:255];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int n_bad_pop = 0;

    always @(posedge clk) begin
        int nrd;
        if (!rst_n) begin
            rd_ptr      <= wr_ptr;
            fifo_rdata  <= '0;
            fifo_rempty <= 1'b1;
        end else begin
            nrd = rd_ptr;
            if (fifo_re) begin
                if (nrd == wr_ptr) begin
                    n_bad_pop <= n_bad_pop + 1;
                end else begin
                    fifo_rdata <= mem[nrd[7:0]];
                    nrd = nrd + 1;
                end
            end
            rd_ptr      <= nrd;
            fifo_rempty <= (nrd == wr_ptr);
        end
    end

    // Reference: words that must appear on the stream, in order.
    logic [DW:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_hs = 0;
    int          rb = 0;
    bit          chk_out = 0;
    bit          stall_hold = 0;
    logic [DW-1:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, return 2 time units after the
    // next rising edge, where the caller drives new inputs.
    task automatic cyc();
        logic [31:0] want;
        @(negedge clk);
        if (chk_out) chk("outstanding_le_2", 32'((rd_ptr - rb - n_hs) <= 2), 32'd1);
        if (rst_n && m_valid && m_ready && !flush) begin
            want = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            chk("stream_word", 32'({m_last, m_data}), want);
            n_hs++;
        end
        if (stall_hold) begin
            chk("stall_m_data", 32'(m_data), 32'(held));
            chk("stall_m_valid", 32'(m_valid), 32'd1);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [DW:0] w, input bit expect_out);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
        if (expect_out) exp_q.push_back(w);
    endtask

    // Random payload; 'keep' words (from the front) are expected on the stream.
    task automatic push_frame(input int len, input int keep);
        for (int i = 0; i < len; i++) begin
            push_word({(i == len - 1), DW'($urandom)}, i < keep);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fifo_re"},   32'(fifo_re),   32'd0);
        chk({tag, "_m_valid"},   32'(m_valid),   32'd0);
        chk({tag, "_m_data"},    32'(m_data),    32'd0);
        chk({tag, "_m_last"},    32'(m_last),    32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        cyc();
        cyc();
        exp_q.delete();
        n_hs = 0;
        rb   = wr_ptr;
        check_zero("reset");
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, "_left_undelivered"}, 32'(exp_q.size()), 32'd0);
        cyc();
        cyc();
    endtask

    initial begin
        logic [DW:0] a;
        int          nfr;
        int          n;

        rst_n   = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;

        // Reset state, then an empty FIFO: no reads, no output.
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("empty_fifo_re", 32'(fifo_re), 32'd0);
            chk("empty_m_valid", 32'(m_valid), 32'd0);
            cyc();
        end

        // Preloaded 4-word frame, sink always ready: valid in cycles 2..5.
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = {(i == 4), 8'hA0 + 8'(i)};
            push_word(a, 1'b1);
        end
        cyc();
        for (int k = 0; k < 8; k++) begin
            chk("bp_fifo_re", 32'(fifo_re), 32'(k <= 3));
            chk("bp_m_valid", 32'(m_valid), 32'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                a = {(k == 5), 8'hA0 + 8'(k - 1)};
                chk("bp_word", 32'({m_last, m_data}), 32'(a));
            end
            cyc();
        end
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("bp_drop_cnt", 32'(drop_cnt), 32'd0);

        // Stall for 5 cycles mid-frame.
        do_reset();
        chk_out = 1'b1;
        m_ready = 1'b1;
        push_frame(10, 10);
        n = 0;
        while (n_hs < 3 && n < 50) begin cyc(); n++; end
        chk("stall_reached", 32'(n_hs), 32'd3);
        m_ready    = 1'b0;
        held       = m_data;
        stall_hold = 1'b1;
        repeat (5) cyc();
        stall_hold = 1'b0;
        m_ready    = 1'b1;
        wait_drain("stall", 60);
        chk("stall_frame_cnt", 32'(frame_cnt), 32'd1);
        chk_out = 1'b0;

        // Flush after word 2, followed by an intact 2-word frame.
        do_reset();
        m_ready = 1'b1;
        push_frame(6, 2);
        push_frame(2, 2);
        n = 0;
        while (n_hs < 2 && n < 50) begin cyc(); n++; end
        chk("flush_reached", 32'(n_hs), 32'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_drain("flush", 60);
        repeat (4) cyc();
        chk("flush_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("flush_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);

        // Flush in the cycle the last word of a 2-word frame is in flight.
        do_reset();
        m_ready = 1'b0;
        push_frame(2, 0);
        n = 0;
        while (!m_valid && n < 20) begin cyc(); n++; end
        chk("race_reached", 32'(m_valid), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("race_busy", 32'(busy), 32'd0);
        chk("race_m_valid", 32'(m_valid), 32'd0);
        chk("race_drop_cnt", 32'(drop_cnt), 32'd1);
        m_ready = 1'b1;
        repeat (4) cyc();
        chk("race_m_valid_later", 32'(m_valid), 32'd0);
        chk("race_frame_cnt", 32'(frame_cnt), 32'd0);

        // Random frames with random backpressure.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            chk_out = 1'b1;
            nfr = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++) begin
                push_frame(int'($urandom_range(1, 5)), 99);
            end
            n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                m_ready = 1'($urandom_range(0, 1));
                cyc();
                n++;
            end
            m_ready = 1'b1;
            wait_drain("rand", 10);
            chk("rand_frame_cnt", 32'(frame_cnt), 32'(nfr));
            chk("rand_drop_cnt", 32'(drop_cnt), 32'd0);
            chk_out = 1'b0;
        end

        // Counter saturation with a 2-bit counter, then reset mid-frame.
        do_reset();
        m_ready = 1'b1;
        for (int f = 0; f < 5; f++) push_frame(1, 1);
        wait_drain("sat", 40);
        chk("sat_frame_cnt", 32'(frame_cnt), 32'd3);
        push_frame(6, 6);
        n = 0;
        while (n_hs < 7 && n < 40) begin cyc(); n++; end
        chk("midreset_reached", 32'(n_hs), 32'd7);
        rst_n = 1'b0;
        cyc();
        check_zero("midreset");
        exp_q.delete();
        rst_n = 1'b1;
        cyc();
        check_zero("after_reset");

        chk("no_pop_while_empty", 32'(n_bad_pop), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
